castlab_ws_systolic_array_v2: RTL and testbench

Second-generation weight-stationary systolic array: ROWS x COLS PE grid computing of[c] = sum_r if[r]*w[r][c] for a stream of input vectors.
Adds an internal control FSM, on-chip input skew/output deskew, valid/ready handshakes with global stall, weight reuse across passes, and fixed-point requantisation.
Sits between the input-feature/kernel prefetch buffers and the output-feature writeback in the convolution accelerator.

---
 rtl/castlab_wsa_v2_pkg.sv | 33 +++
 rtl/castlab_ws_pe_v2.sv | 47 ++++
 rtl/castlab_ws_systolic_array_v2.sv | 205 ++++++++++++++++++++
 tb/tb_castlab_ws_systolic_array_v2.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/castlab_wsa_v2_pkg.sv
// Shared types and arithmetic helpers for the weight-stationary systolic array v2.
// CASTLAB_WSA_ROUND_SAT_EN selects round-half-up with saturation; otherwise outputs are truncated.
package castlab_wsa_v2_pkg;

  typedef enum logic [2:0] {IDLE, WLOAD, STREAM, DRAIN, DONE} wsa_state_e;

  function automatic int acc_width(int if_bits, int k_bits, int rows);
    return if_bits + k_bits + $clog2(rows);
  endfunction

  function automatic int shift_amt(int if_frac, int k_frac, int of_frac);
    return if_frac + k_frac - of_frac;
  endfunction

  // Returns the requantised value; the caller keeps the low of_bits bits.
  function automatic longint requant(longint acc, int shift, int of_bits);
    longint r;
`ifdef CASTLAB_WSA_ROUND_SAT_EN
    longint hi, lo;
    hi = (longint'(1) <<< (of_bits - 1)) - 1;
    lo = -(longint'(1) <<< (of_bits - 1));
    r = acc;
    if (shift > 0) r = r + (longint'(1) <<< (shift - 1));
    r = r >>> shift;
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
`else
    r = (acc >>> shift) & ((longint'(1) <<< of_bits) - 1);
`endif
    return r;
  endfunction

endpackage

// File: rtl/castlab_ws_pe_v2.sv
// Weight-stationary PE: holds one weight, forwards the input rightward and the
// partial sum downward, all gated by the array-wide stall enable.
module castlab_ws_pe_v2
  import castlab_wsa_v2_pkg::*;
#(
  parameter int IF_W  = 8,
  parameter int K_W   = 8,
  parameter int ACC_W = 18
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    w_load,
  input  logic [K_W-1:0]          w_data,
  input  logic [IF_W-1:0]         if_in,
  input  logic                    v_in,
  input  logic signed [ACC_W-1:0] psum_in,
  output logic [IF_W-1:0]         if_out,
  output logic                    v_out,
  output logic signed [ACC_W-1:0] psum_out
);

  logic [K_W-1:0]          w_q;
  logic signed [ACC_W-1:0] if_x, w_x;

  assign if_x = ACC_W'($signed(if_in));
  assign w_x  = ACC_W'($signed(w_q));

  // Weight loading happens only while the pipeline is empty, so it ignores en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         w_q <= '0;
    else if (w_load) w_q <= w_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_out   <= '0;
      v_out    <= 1'b0;
      psum_out <= '0;
    end else if (en) begin
      if_out   <= if_in;
      v_out    <= v_in;
      psum_out <= psum_in + if_x * w_x;
    end
  end

endmodule

// File: rtl/castlab_ws_systolic_array_v2.sv
// ROWS x COLS weight-stationary array with control FSM, skew/deskew, handshakes and requantisation.
// Optional macro CASTLAB_WSA_ROUND_SAT_EN enables round-half-up + saturation (default: truncation).
module castlab_ws_systolic_array_v2
  import castlab_wsa_v2_pkg::*;
#(
  parameter int ROWS        = 4,
  parameter int COLS        = 4,
  parameter int IF_BITWIDTH = 8,
  parameter int IF_FRAC_BIT = 4,
  parameter int K_BITWIDTH  = 8,
  parameter int K_FRAC_BIT  = 4,
  parameter int OF_BITWIDTH = 16,
  parameter int OF_FRAC_BIT = 8,
  parameter int VEC_CNT_W   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_start,
  input  logic [VEC_CNT_W-1:0]          cfg_num_vec,
  input  logic                          cfg_reuse_w,
  input  logic                          w_i_valid,
  output logic                          w_i_ready,
  input  logic [COLS*K_BITWIDTH-1:0]    w_i_data,
  input  logic                          if_i_valid,
  output logic                          if_i_ready,
  input  logic [ROWS*IF_BITWIDTH-1:0]   if_i_data,
  output logic                          of_o_valid,
  input  logic                          of_o_ready,
  output logic [COLS*OF_BITWIDTH-1:0]   of_o_data,
  output logic                          busy,
  output logic                          done
);

  localparam int ACC_W = acc_width(IF_BITWIDTH, K_BITWIDTH, ROWS);
  localparam int SHIFT = shift_amt(IF_FRAC_BIT, K_FRAC_BIT, OF_FRAC_BIT);
  localparam int RCW   = (ROWS > 1) ? $clog2(ROWS) : 1;

  wsa_state_e             state, state_nx;
  logic [RCW-1:0]         row_cnt;
  logic [VEC_CNT_W-1:0]   num_vec, in_cnt, out_cnt;
  logic                   en, in_room, if_hs, of_hs, w_we;

  assign en      = !(of_o_valid && !of_o_ready);
  assign in_room = en && (in_cnt < num_vec);
  assign if_hs   = if_i_valid && if_i_ready;
  assign of_hs   = of_o_valid && of_o_ready;
  assign w_we    = (state == WLOAD) && w_i_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    busy       = (state != IDLE);
    done       = 1'b0;
    w_i_ready  = 1'b0;
    if_i_ready = 1'b0;
    case (state)
      IDLE:   if (cfg_start) state_nx = cfg_reuse_w ? STREAM : WLOAD;
      WLOAD: begin
        w_i_ready = 1'b1;
        if (w_i_valid && row_cnt == RCW'(ROWS - 1)) state_nx = STREAM;
      end
      STREAM: begin
        if_i_ready = in_room;
        if (if_i_valid && in_room && in_cnt == num_vec - VEC_CNT_W'(1)) state_nx = DRAIN;
      end
      DRAIN:  if (out_cnt == num_vec) state_nx = DONE;
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_cnt <= '0;
      num_vec <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      if (state == IDLE && cfg_start) begin
        num_vec <= cfg_num_vec;
        row_cnt <= '0;
        in_cnt  <= '0;
        out_cnt <= '0;
      end
      if (w_we)  row_cnt <= row_cnt + RCW'(1);
      if (if_hs) in_cnt  <= in_cnt + VEC_CNT_W'(1);
      if (of_hs) out_cnt <= out_cnt + VEC_CNT_W'(1);
    end
  end

  logic [IF_BITWIDTH-1:0]  if_h [ROWS][COLS+1];
  logic                    v_h  [ROWS][COLS+1];
  logic signed [ACC_W-1:0] ps_v [ROWS+1][COLS];
  logic signed [ACC_W-1:0] dsk_out [COLS];
  logic                    dsk_v;

  // Row r sits behind r+1 registers; the first stage doubles as the acceptance register.
  for (genvar r = 0; r < ROWS; r++) begin : g_skew
    logic [IF_BITWIDTH-1:0] sd [r+1];
    logic                   sv [r+1];
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int unsigned i = 0; i <= r; i++) begin
          sd[i] <= '0;
          sv[i] <= 1'b0;
        end
      end else if (en) begin
        sd[0] <= if_i_data[r*IF_BITWIDTH +: IF_BITWIDTH];
        sv[0] <= if_hs;
        for (int unsigned i = 1; i <= r; i++) begin
          sd[i] <= sd[i-1];
          sv[i] <= sv[i-1];
        end
      end
    end
    assign if_h[r][0] = sd[r];
    assign v_h[r][0]  = sv[r];
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      if (r == 0) begin : g_top
        assign ps_v[0][c] = '0;
      end
      castlab_ws_pe_v2 #(
        .IF_W  (IF_BITWIDTH),
        .K_W   (K_BITWIDTH),
        .ACC_W (ACC_W)
      ) u_pe (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .w_load   (w_we && (row_cnt == RCW'(r))),
        .w_data   (w_i_data[c*K_BITWIDTH +: K_BITWIDTH]),
        .if_in    (if_h[r][c]),
        .v_in     (v_h[r][c]),
        .psum_in  (ps_v[r][c]),
        .if_out   (if_h[r][c+1]),
        .v_out    (v_h[r][c+1]),
        .psum_out (ps_v[r+1][c])
      );
    end
  end

  // Column c leaves the bottom row c cycles after column 0; delay it COLS-1-c more to realign.
  for (genvar c = 0; c < COLS; c++) begin : g_dsk
    localparam int unsigned L = COLS - 1 - c;
    if (L == 0) begin : g_pass
      assign dsk_out[c] = ps_v[ROWS][c];
    end else begin : g_dly
      logic signed [ACC_W-1:0] d [L];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int unsigned i = 0; i < L; i++) d[i] <= '0;
        end else if (en) begin
          d[0] <= ps_v[ROWS][c];
          for (int unsigned i = 1; i < L; i++) d[i] <= d[i-1];
        end
      end
      assign dsk_out[c] = d[L-1];
    end
  end

  if (COLS > 1) begin : g_dv
    logic dv [COLS-1];
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int unsigned i = 0; i < COLS - 1; i++) dv[i] <= 1'b0;
      end else if (en) begin
        dv[0] <= v_h[ROWS-1][1];
        for (int unsigned i = 1; i < COLS - 1; i++) dv[i] <= dv[i-1];
      end
    end
    assign dsk_v = dv[COLS-2];
  end else begin : g_dv0
    assign dsk_v = v_h[ROWS-1][1];
  end

  logic [COLS*OF_BITWIDTH-1:0] of_nx;

  always_comb begin
    of_nx = '0;
    for (int unsigned c = 0; c < COLS; c++)
      of_nx[c*OF_BITWIDTH +: OF_BITWIDTH] =
        OF_BITWIDTH'(requant(longint'(dsk_out[c]), SHIFT, OF_BITWIDTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      of_o_valid <= 1'b0;
      of_o_data  <= '0;
    end else if (en) begin
      of_o_valid <= dsk_v;
      of_o_data  <= of_nx;
    end
  end

endmodule

// File: tb/tb_castlab_ws_systolic_array_v2.sv
// Scoreboard bench for castlab_ws_systolic_array_v2: drivers push expected vectors,
// a negedge monitor pops and compares on every output handshake.
module tb_castlab_ws_systolic_array_v2;
  localparam int ROWS = 4, COLS = 4, IFW = 8, KW = 8, OFW = 16, VCW = 16;

`ifdef CASTLAB_WSA_ROUND_SAT_EN
  localparam logic [15:0] EXP_POS = 16'h7FFF;
  localparam logic [15:0] EXP_NEG = 16'h8000;
`else
  localparam logic [15:0] EXP_POS = 16'hFC04;   // 4*127*127 = 64516
  localparam logic [15:0] EXP_NEG = 16'h0200;   // -65024 mod 2^16
`endif

  logic clk = 1'b0;
  logic rst, cfg_start, cfg_reuse_w;
  logic [VCW-1:0] cfg_num_vec;
  logic w_i_valid, w_i_ready, if_i_valid, if_i_ready, of_o_valid, of_o_ready, busy, done;
  logic [COLS*KW-1:0]  w_i_data;
  logic [ROWS*IFW-1:0] if_i_data;
  logic [COLS*OFW-1:0] of_o_data;

  always #5 clk = ~clk;

  castlab_ws_systolic_array_v2 #(
    .ROWS(ROWS), .COLS(COLS), .IF_BITWIDTH(IFW), .IF_FRAC_BIT(4), .K_BITWIDTH(KW),
    .K_FRAC_BIT(4), .OF_BITWIDTH(OFW), .OF_FRAC_BIT(8), .VEC_CNT_W(VCW)
  ) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_num_vec(cfg_num_vec),
    .cfg_reuse_w(cfg_reuse_w), .w_i_valid(w_i_valid), .w_i_ready(w_i_ready),
    .w_i_data(w_i_data), .if_i_valid(if_i_valid), .if_i_ready(if_i_ready),
    .if_i_data(if_i_data), .of_o_valid(of_o_valid), .of_o_ready(of_o_ready),
    .of_o_data(of_o_data), .busy(busy), .done(done)
  );

  int checks = 0, failures = 0;
  int popped = 0, done_cnt = 0, wrdy_seen = 0, ready_mode = 0;
  bit in_reuse = 1'b0;
  logic [7:0]  wm [ROWS][COLS];
  logic [31:0] vec_list [$];
  logic [63:0] exp_list [$];
  logic [63:0] exp_q [$];
  logic [63:0] exp_v;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Plain dot product; SHIFT is 0 for these parameters so no rounding term applies.
  function automatic logic [63:0] model(logic [31:0] vec);
    logic [63:0] res;
    longint acc, q;
    res = '0;
    for (int c = 0; c < COLS; c++) begin
      acc = 0;
      for (int r = 0; r < ROWS; r++)
        acc += longint'($signed(vec[r*IFW +: IFW])) * longint'($signed(wm[r][c]));
      q = acc;
`ifdef CASTLAB_WSA_ROUND_SAT_EN
      if (q > 32767) q = 32767;
      else if (q < -32768) q = -32768;
`endif
      res[c*OFW +: OFW] = q[15:0];
    end
    return res;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (of_o_valid && of_o_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=%h required=none", of_o_data);
        end else begin
          exp_v = exp_q.pop_front();
          check("of_o_data", of_o_data, exp_v);
        end
        popped++;
      end
      if (done) done_cnt++;
      if (in_reuse && w_i_ready) wrdy_seen++;
    end
  end

  initial begin
    of_o_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      of_o_ready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send_w(logic [31:0] row);
    bit hs = 1'b0;
    int t = 0;
    w_i_valid = 1'b1;
    w_i_data  = row;
    while (!hs && t < 200) begin
      @(negedge clk); hs = w_i_ready;
      @(posedge clk); #1; t++;
    end
    w_i_valid = 1'b0;
    check("w_handshake", 64'(hs), 1);
  endtask

  task automatic send_if(logic [31:0] v, logic [63:0] e);
    bit hs = 1'b0;
    int t = 0;
    if_i_valid = 1'b1;
    if_i_data  = v;
    while (!hs && t < 200) begin
      @(negedge clk); hs = if_i_ready;
      if (hs) exp_q.push_back(e);
      @(posedge clk); #1; t++;
    end
    if_i_valid = 1'b0;
    check("if_handshake", 64'(hs), 1);
  endtask

  task automatic start_pass(int n, bit reuse);
    cfg_start = 1'b1; cfg_num_vec = VCW'(n); cfg_reuse_w = reuse;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic load_weights();
    logic [31:0] row;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) row[c*KW +: KW] = wm[r][c];
      send_w(row);
    end
  endtask

  task automatic run_pass(int n, bit reuse, int gap_max, bit lat_chk);
    int base_pop, base_done, t;
    start_pass(n, reuse);
    in_reuse = reuse; wrdy_seen = 0;
    base_pop = popped; base_done = done_cnt;
    if (!reuse) load_weights();
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
      send_if(vec_list[i], exp_list[i]);
      if (lat_chk && i == 0) begin
        repeat (7) @(posedge clk);
        @(negedge clk); check("latency_early", 64'(of_o_valid), 0);
        @(posedge clk);
        @(negedge clk); check("latency_on_time", 64'(of_o_valid), 1);
        @(posedge clk); #1;
      end
    end
    t = 0;
    while (done_cnt == base_done && t < 1000) begin @(posedge clk); #1; t++; end
    check("done_pulses", 64'(done_cnt - base_done), 1);
    check("outputs_at_done", 64'(popped - base_pop), 64'(n));
    @(negedge clk); check("done_one_cycle", 64'(done), 0);
    @(posedge clk); #1;
    if (reuse) check("reuse_no_w_ready", 64'(wrdy_seen), 0);
    in_reuse = 1'b0;
    check("scoreboard_empty", 64'(exp_q.size()), 0);
  endtask

  task automatic fill_vectors(int n, int seed);
    logic [31:0] v;
    vec_list.delete(); exp_list.delete();
    for (int i = 0; i < n; i++) begin
      for (int r = 0; r < ROWS; r++) v[r*IFW +: IFW] = 8'(i*29 + r*53 + seed*7 - 100);
      vec_list.push_back(v);
      exp_list.push_back(model(v));
    end
  endtask

  initial begin
    int base_pop, base_done;
    rst = 1'b1; cfg_start = 1'b0; cfg_num_vec = '0; cfg_reuse_w = 1'b0;
    w_i_valid = 1'b0; w_i_data = '0; if_i_valid = 1'b0; if_i_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_of_o_valid", 64'(of_o_valid), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_w_i_ready", 64'(w_i_ready), 0);
    check("rst_if_i_ready", 64'(if_i_ready), 0);
    check("rst_of_o_data", of_o_data, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    // identity weights, latency check
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) wm[r][c] = (r == c) ? 8'h10 : 8'h00;
    vec_list = '{32'h40302010};
    exp_list = '{64'h0400_0300_0200_0100};
    run_pass(1, 1'b0, 0, 1'b1);

    // positive extreme
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) wm[r][c] = 8'h7F;
    vec_list = '{32'h7F7F7F7F};
    exp_list = '{{4{EXP_POS}}};
    run_pass(1, 1'b0, 0, 1'b0);

    // negative extreme
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) wm[r][c] = 8'h80;
    exp_list = '{{4{EXP_NEG}}};
    run_pass(1, 1'b0, 0, 1'b0);

    // 16 back-to-back vectors with output backpressure, then weight reuse
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) wm[r][c] = 8'(r*23 - c*41 + 5);
    fill_vectors(16, 0);
    ready_mode = 1;
    run_pass(16, 1'b0, 0, 1'b0);
    run_pass(16, 1'b1, 0, 1'b0);

    // input gaps inject bubbles
    fill_vectors(12, 3);
    run_pass(12, 1'b1, 3, 1'b0);
    ready_mode = 0;

    // reset in the middle of streaming
    fill_vectors(10, 5);
    start_pass(10, 1'b1);
    for (int i = 0; i < 5; i++) send_if(vec_list[i], exp_list[i]);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midrst_of_o_valid", 64'(of_o_valid), 0);
    check("midrst_busy", 64'(busy), 0);
    check("midrst_done", 64'(done), 0);
    base_pop = popped; base_done = done_cnt;
    @(posedge clk); #1; rst = 1'b0;
    repeat (12) begin @(posedge clk); #1; end
    check("midrst_no_outputs", 64'(popped - base_pop), 0);
    check("midrst_no_done", 64'(done_cnt - base_done), 0);

    fill_vectors(4, 9);
    run_pass(4, 1'b0, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
